// File: rtl/decode_queue_if.sv
// Fetch-side and decode-side signals of the decode queue.
// The master modport is the fetch/decode environment; the slave modport is the queue.
interface decode_queue_if #(
  parameter int unsigned RV    = 32,
  parameter int unsigned FW    = 32,
  parameter int unsigned ISSUE = 2
);
  localparam int unsigned PW = FW / 16;
  localparam int unsigned SW = (PW > 1) ? $clog2(PW) : 1;
  localparam int unsigned TW = $clog2(ISSUE + 1);

  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [FW-1:0]         fetch_data;
  logic [RV-1:0]         fetch_pc;
  logic [SW-1:0]         fetch_start;
  logic                  flush;
  logic [ISSUE-1:0]      dec_valid;
  logic [16*ISSUE-1:0]   dec_ins;
  logic [RV-1:0]         dec_pc;
  logic [TW-1:0]         dec_take;

  modport master (
    output fetch_valid, fetch_data, fetch_pc, fetch_start, flush, dec_take,
    input  fetch_ready, dec_valid, dec_ins, dec_pc
  );

  modport slave (
    input  fetch_valid, fetch_data, fetch_pc, fetch_start, flush, dec_take,
    output fetch_ready, dec_valid, dec_ins, dec_pc
  );
endinterface

// File: rtl/decode_queue.sv
// Instruction-parcel queue between fetch and the 16-bit decoder.
// Fetch words are split into 16-bit parcels held in a circular store; decode
// sees up to ISSUE consecutive parcels starting at the head, plus the head PC.
module decode_queue #(
  parameter int unsigned RV    = 32,
  parameter int unsigned FW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ISSUE = 2
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave bus
);
  localparam int unsigned PW = FW / 16;
  localparam int unsigned SW = (PW > 1) ? $clog2(PW) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   store_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [RV-1:0] head_pc_q, head_pc_d;
  logic          pc_set_q, pc_set_d;

  logic [CW-1:0] free;
  logic [CW-1:0] n_push;
  logic [CW-1:0] n_take;
  logic          push;

  // Handshake and per-cycle push/pop amounts; ready ignores any same-cycle take.
  always_comb begin
    free            = CW'(DEPTH) - count_q;
    bus.fetch_ready = !reset && !bus.flush && (free >= CW'(PW));
    push            = bus.fetch_valid && bus.fetch_ready;
    n_push          = CW'(PW) - CW'(bus.fetch_start);
    // Over-large takes are clamped to what is held.
    n_take          = (CW'(bus.dec_take) > count_q) ? count_q : CW'(bus.dec_take);
  end

  // Next-state for pointers, occupancy and head PC; flush overrides everything.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    pc_set_d  = pc_set_q;
    if (bus.flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      pc_set_d = 1'b0;
      // head_pc is kept; the next push reloads it.
    end else begin
      head_d  = head_q + AW'(n_take);
      tail_d  = push ? (tail_q + AW'(n_push)) : tail_q;
      count_d = count_q + (push ? n_push : '0) - n_take;
      if (push && !pc_set_q) begin
        // First word after reset/flush: PC of the first valid parcel.
        head_pc_d = bus.fetch_pc + RV'({bus.fetch_start, 1'b0});
        pc_set_d  = 1'b1;
      end else begin
        head_pc_d = head_pc_q + RV'({n_take, 1'b0});
      end
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
      pc_set_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      pc_set_q  <= pc_set_d;
    end
  end

  // Parcel store write: parcels fetch_start..PW-1 land at tail, tail+1, ...
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned k = 0; k < PW; k++) begin
        if (SW'(k) >= bus.fetch_start) begin
          store_q[tail_q + AW'(k) - AW'(bus.fetch_start)] <= bus.fetch_data[16*k +: 16];
        end
      end
    end
  end

  // Decode-side view: slot i is the parcel at head+i, PC is the head PC.
  always_comb begin
    bus.dec_valid = '0;
    bus.dec_ins   = '0;
    for (int unsigned i = 0; i < ISSUE; i++) begin
      bus.dec_valid[i]        = (count_q > CW'(i));
      bus.dec_ins[16*i +: 16] = store_q[head_q + AW'(i)];
    end
    bus.dec_pc = head_pc_q;
  end
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed and random steps on a FW=32/ISSUE=2 instance
// checked against a parcel-queue model, plus a short FW=64/ISSUE=1 directed run.
module tb_decode_queue;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.RV(32), .FW(32), .ISSUE(2)) bus0 ();
  decode_queue_if #(.RV(32), .FW(64), .ISSUE(1)) bus1 ();

  decode_queue #(.RV(32), .FW(32), .DEPTH(8), .ISSUE(2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  decode_queue #(.RV(32), .FW(64), .DEPTH(8), .ISSUE(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Reference model: parcels in order, head PC, and whether it has been loaded.
  logic [15:0] mq[$];
  logic [31:0] m_pc;
  bit          m_set;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out();
    chk("dec_valid", 64'(bus0.dec_valid), 64'({mq.size() > 1, mq.size() > 0}));
    if (mq.size() > 0) chk("slot0", 64'(bus0.dec_ins[15:0]), 64'(mq[0]));
    if (mq.size() > 1) chk("slot1", 64'(bus0.dec_ins[31:16]), 64'(mq[1]));
    chk("dec_pc", 64'(bus0.dec_pc), 64'(m_pc));
  endtask

  // One cycle on dut0, starting and ending at a falling edge.
  task automatic step(input bit v, input logic [31:0] d, input logic [31:0] pc,
                      input bit st, input bit fl, input logic [1:0] tk);
    bit rdy;
    int eff;
    bus0.fetch_valid = v;
    bus0.fetch_data  = d;
    bus0.fetch_pc    = pc;
    bus0.fetch_start = st;
    bus0.flush       = fl;
    bus0.dec_take    = tk;
    #1;
    rdy = !fl && ((8 - mq.size()) >= 2);
    chk("fetch_ready", 64'(bus0.fetch_ready), 64'(rdy));
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_set = 1'b0;
    end else begin
      eff = (int'(tk) > mq.size()) ? mq.size() : int'(tk);
      repeat (eff) void'(mq.pop_front());
      if (v && rdy) begin
        for (int k = int'(st); k < 2; k++) mq.push_back(d[16*k +: 16]);
      end
      if (v && rdy && !m_set) begin
        m_pc  = pc + 32'(2 * int'(st));
        m_set = 1'b1;
      end else begin
        m_pc = m_pc + 32'(2 * eff);
      end
    end
    @(negedge clk);
    chk_out();
  endtask

  initial begin
    reset            = 1'b1;
    bus0.fetch_valid = 1'b0;
    bus0.fetch_data  = '0;
    bus0.fetch_pc    = '0;
    bus0.fetch_start = '0;
    bus0.flush       = 1'b0;
    bus0.dec_take    = '0;
    bus1.fetch_valid = 1'b0;
    bus1.fetch_data  = '0;
    bus1.fetch_pc    = '0;
    bus1.fetch_start = '0;
    bus1.flush       = 1'b0;
    bus1.dec_take    = '0;
    m_pc  = '0;
    m_set = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready0", 64'(bus0.fetch_ready), 64'(0));
    chk("rst_ready1", 64'(bus1.fetch_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk_out();

    // FW=64, ISSUE=1 instance: one word, then single-parcel takes.
    bus1.fetch_valid = 1'b1;
    bus1.fetch_data  = 64'h4444_3333_2222_1111;
    bus1.fetch_pc    = 32'h300;
    #1;
    chk("w64_ready", 64'(bus1.fetch_ready), 64'(1));
    @(negedge clk);
    bus1.fetch_valid = 1'b0;
    chk("w64_valid", 64'(bus1.dec_valid), 64'(1));
    chk("w64_ins0", 64'(bus1.dec_ins), 64'h1111);
    chk("w64_pc0", 64'(bus1.dec_pc), 64'h300);
    bus1.dec_take = 1'b1;
    @(negedge clk);
    chk("w64_ins1", 64'(bus1.dec_ins), 64'h2222);
    chk("w64_pc1", 64'(bus1.dec_pc), 64'h302);
    @(negedge clk);
    chk("w64_ins2", 64'(bus1.dec_ins), 64'h3333);
    chk("w64_pc2", 64'(bus1.dec_pc), 64'h304);
    bus1.dec_take = 1'b0;

    // Basic push and full take.
    step(1, 32'h2222_1111, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2);
    // Unaligned target after a redirect.
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'hBBBB_AAAA, 32'h200, 1, 0, 0);
    step(1, 32'hDDDD_CCCC, 32'h204, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 2);                  // clamped take of 1
    // Fill and back-pressure.
    repeat (4) step(1, $urandom, 0, 0, 0, 0);
    step(1, $urandom, 0, 0, 0, 0);            // refused, queue full
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 2);                   // 7 held: still not ready
    step(0, 0, 0, 0, 0, 0);                   // 5 held: ready
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 1);
    // Concurrent push and take, running the pointers past the wrap.
    repeat (7) step(1, $urandom, 0, 0, 0, 2);
    // Clamp, then flush with a push offered.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 2);
    step(1, $urandom, 0, 0, 0, 0);
    step(1, $urandom, 32'h600, 0, 1, 2);
    step(1, 32'h8888_7777, 32'h800, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step(($urandom % 4) != 0, $urandom, $urandom & 32'hFFFF_FFFE,
           ($urandom % 8) == 0, ($urandom % 20) == 0, 2'($urandom % 3));
    end

    // Asynchronous reset with five parcels held.
    step(0, 0, 0, 0, 1, 0);
    step(1, $urandom, 32'h900, 0, 0, 0);
    step(1, $urandom, 0, 0, 0, 0);
    step(1, $urandom, 0, 0, 0, 1);
    chk("pre_reset_valid", 64'(bus0.dec_valid), 64'(2'b11));
    bus0.fetch_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(bus0.dec_valid), 64'(0));
    chk("async_ready", 64'(bus0.fetch_ready), 64'(0));
    mq.delete();
    m_pc  = '0;
    m_set = 1'b0;
    bus0.fetch_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_out();
    step(1, 32'h2222_1111, 32'h100, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
